// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiplier controller.
//   - state_t and the St* constants: controller phase encoding
//   - clog2_min1(): address/index width helper, never narrower than 1 bit
package mvm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StRst   = 3'd0;
    localparam state_t StIdle  = 3'd1;
    localparam state_t StLoadW = 3'd2;
    localparam state_t StLoadX = 3'd3;
    localparam state_t StMult  = 3'd4;
    localparam state_t StDrain = 3'd5;
    localparam state_t StSend  = 3'd6;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_wrap_counter.sv
// Modulo-MAX up-counter.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : advance by one (wraps to 0 after MAX-1)
//   cnt_o         : current count
//   done_o        : count is at its terminal value MAX-1
module mvm_wrap_counter #(
    parameter int unsigned MAX   = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == WIDTH'(MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = done_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mvm_control.sv
// Control FSM for a ROWS x COLS matrix-vector multiplier.
// Loads W (optional) and x through a valid/ready input stream, steps the MAC
// row by row, and hands each row result to a valid/ready output stream.
//   input_valid_i/input_ready_o/new_matrix_i : input word stream
//   addr_w_o/wr_en_w_o, addr_x_o/wr_en_x_o   : W and x memory ports
//   en_acc_o/clear_acc_o                     : accumulator control
//   output_valid_o/output_ready_i            : result stream
//   row_idx_o/last_row_o                     : result tagging
module mvm_control
    import mvm_pkg::*;
#(
    parameter int unsigned ROWS    = 3,
    parameter int unsigned COLS    = 3,
    parameter int unsigned MAC_LAT = 1,
    parameter int unsigned XW      = clog2_min1(COLS),
    parameter int unsigned WW      = clog2_min1(ROWS * COLS),
    parameter int unsigned RW      = clog2_min1(ROWS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          input_valid_i,
    input  logic          new_matrix_i,
    output logic          input_ready_o,
    output logic [WW-1:0] addr_w_o,
    output logic          wr_en_w_o,
    output logic [XW-1:0] addr_x_o,
    output logic          wr_en_x_o,
    output logic          en_acc_o,
    output logic          clear_acc_o,
    output logic          output_valid_o,
    input  logic          output_ready_i,
    output logic [RW-1:0] row_idx_o,
    output logic          last_row_o
);

    localparam int unsigned DW = clog2_min1(MAC_LAT);

    state_t               state_q, state_d;
    logic [WW-1:0]        base_q, base_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [MAC_LAT-1:0]   en_pipe_q;

    logic [WW-1:0] wcnt;
    logic [XW-1:0] xcnt, col;
    logic [RW-1:0] row;
    logic          wcnt_done, xcnt_done, col_done, row_done;
    logic          in_mult, in_send, load_w_acc, load_x_acc, handshake;

    assign in_mult   = (state_q == StMult);
    assign in_send   = (state_q == StSend);
    // new_matrix_i only matters for the first word, accepted in IDLE
    assign load_w_acc = input_valid_i &
                        (((state_q == StIdle) & new_matrix_i) | (state_q == StLoadW));
    assign load_x_acc = input_valid_i &
                        (((state_q == StIdle) & ~new_matrix_i) | (state_q == StLoadX));
    assign handshake = in_send & output_ready_i;

    mvm_wrap_counter #(.MAX(ROWS * COLS), .WIDTH(WW)) u_wcnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (load_w_acc),
        .cnt_o (wcnt),
        .done_o(wcnt_done)
    );

    mvm_wrap_counter #(.MAX(COLS), .WIDTH(XW)) u_xcnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (load_x_acc),
        .cnt_o (xcnt),
        .done_o(xcnt_done)
    );

    mvm_wrap_counter #(.MAX(COLS), .WIDTH(XW)) u_col (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (in_mult),
        .cnt_o (col),
        .done_o(col_done)
    );

    mvm_wrap_counter #(.MAX(ROWS), .WIDTH(RW)) u_row (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (handshake),
        .cnt_o (row),
        .done_o(row_done)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        drain_d = drain_q;
        case (state_q)
            StRst:   state_d = StLoadW;
            StIdle:  if (input_valid_i) state_d = new_matrix_i ? StLoadW : StLoadX;
            StLoadW: if (input_valid_i && wcnt_done) state_d = StLoadX;
            StLoadX: if (input_valid_i && xcnt_done) state_d = StMult;
            StMult:  if (col_done) state_d = StDrain;
            StDrain: begin
                // Wait until the last MULT beat has reached en_acc_o
                if (drain_q == DW'(MAC_LAT - 1)) begin
                    drain_d = '0;
                    state_d = StSend;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            StSend: begin
                if (output_ready_i) begin
                    if (row_done) begin
                        base_d  = '0;
                        state_d = StIdle;
                    end else begin
                        base_d  = base_q + WW'(COLS);
                        state_d = StMult;
                    end
                end
            end
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        input_ready_o  = (state_q == StIdle) | (state_q == StLoadW) | (state_q == StLoadX);
        wr_en_w_o      = load_w_acc;
        wr_en_x_o      = load_x_acc;
        addr_w_o       = '0;
        addr_x_o       = '0;
        if (load_w_acc) addr_w_o = wcnt;
        if (load_x_acc) addr_x_o = xcnt;
        if (in_mult) begin
            addr_w_o = base_q + WW'(col);
            addr_x_o = col;
        end
        en_acc_o       = en_pipe_q[MAC_LAT-1];
        clear_acc_o    = (state_q == StRst) | handshake;
        output_valid_o = in_send;
        row_idx_o      = in_send ? row : '0;
        last_row_o     = in_send & row_done;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRst;
            base_q    <= '0;
            drain_q   <= '0;
            en_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            drain_q   <= drain_d;
            en_pipe_q <= (en_pipe_q << 1) | MAC_LAT'(in_mult);
        end
    end

endmodule

// File: tb/tb_mvm_control.sv
// Bench for mvm_control: two instances (3x3 lat 1, 4x2 lat 3) driven with
// randomized input gaps, stray input words, random new_matrix and random
// output back-pressure; expectations come from word/cycle arithmetic.
module tb_mvm_control;
    import mvm_pkg::*;

    localparam int R0 = 3, C0 = 3, L0 = 1;
    localparam int R1 = 4, C1 = 2, L1 = 3;
    localparam int unsigned WW0 = clog2_min1(R0 * C0);
    localparam int unsigned XW0 = clog2_min1(C0);
    localparam int unsigned RW0 = clog2_min1(R0);
    localparam int unsigned WW1 = clog2_min1(R1 * C1);
    localparam int unsigned XW1 = clog2_min1(C1);
    localparam int unsigned RW1 = clog2_min1(R1);

    logic clk;
    logic rst_n[2];
    logic in_valid[2];
    logic new_mat[2];
    logic out_ready[2];

    logic o_ir[2], o_wew[2], o_wex[2], o_en[2], o_clr[2], o_ov[2], o_last[2];
    logic [7:0] o_addr_w[2], o_addr_x[2], o_row[2];

    logic [WW0-1:0] a_addr_w;
    logic [XW0-1:0] a_addr_x;
    logic [RW0-1:0] a_row;
    logic [WW1-1:0] b_addr_w;
    logic [XW1-1:0] b_addr_x;
    logic [RW1-1:0] b_row;

    assign o_addr_w[0] = 8'(a_addr_w);
    assign o_addr_x[0] = 8'(a_addr_x);
    assign o_row[0]    = 8'(a_row);
    assign o_addr_w[1] = 8'(b_addr_w);
    assign o_addr_x[1] = 8'(b_addr_x);
    assign o_row[1]    = 8'(b_row);

    mvm_control #(.ROWS(R0), .COLS(C0), .MAC_LAT(L0)) u_dut0 (
        .clk_i         (clk),
        .rst_ni        (rst_n[0]),
        .input_valid_i (in_valid[0]),
        .new_matrix_i  (new_mat[0]),
        .input_ready_o (o_ir[0]),
        .addr_w_o      (a_addr_w),
        .wr_en_w_o     (o_wew[0]),
        .addr_x_o      (a_addr_x),
        .wr_en_x_o     (o_wex[0]),
        .en_acc_o      (o_en[0]),
        .clear_acc_o   (o_clr[0]),
        .output_valid_o(o_ov[0]),
        .output_ready_i(out_ready[0]),
        .row_idx_o     (a_row),
        .last_row_o    (o_last[0])
    );

    mvm_control #(.ROWS(R1), .COLS(C1), .MAC_LAT(L1)) u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n[1]),
        .input_valid_i (in_valid[1]),
        .new_matrix_i  (new_mat[1]),
        .input_ready_o (o_ir[1]),
        .addr_w_o      (b_addr_w),
        .wr_en_w_o     (o_wew[1]),
        .addr_x_o      (b_addr_x),
        .wr_en_x_o     (o_wex[1]),
        .en_acc_o      (o_en[1]),
        .clear_acc_o   (o_clr[1]),
        .output_valid_o(o_ov[1]),
        .output_ready_i(out_ready[1]),
        .row_idx_o     (b_row),
        .last_row_o    (o_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rows_of(input int k);
        return (k == 0) ? R0 : R1;
    endfunction
    function automatic int cols_of(input int k);
        return (k == 0) ? C0 : C1;
    endfunction
    function automatic int lat_of(input int k);
        return (k == 0) ? L0 : L1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check async values, release, check the RST cycle.
    task automatic reset_dut(input int k);
        rst_n[k]    = 1'b0;
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b0;
        #1;
        check_eq($sformatf("u%0d rst clear_acc", k), 32'(o_clr[k]), 1);
        check_eq($sformatf("u%0d rst input_ready", k), 32'(o_ir[k]), 0);
        check_eq($sformatf("u%0d rst wr_en_w", k), 32'(o_wew[k]), 0);
        check_eq($sformatf("u%0d rst wr_en_x", k), 32'(o_wex[k]), 0);
        check_eq($sformatf("u%0d rst en_acc", k), 32'(o_en[k]), 0);
        check_eq($sformatf("u%0d rst output_valid", k), 32'(o_ov[k]), 0);
        check_eq($sformatf("u%0d rst last_row", k), 32'(o_last[k]), 0);
        check_eq($sformatf("u%0d rst addr_w", k), 32'(o_addr_w[k]), 0);
        check_eq($sformatf("u%0d rst addr_x", k), 32'(o_addr_x[k]), 0);
        check_eq($sformatf("u%0d rst row_idx", k), 32'(o_row[k]), 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n[k] = 1'b1;
        @(negedge clk);
        check_eq($sformatf("u%0d post-rst clear_acc", k), 32'(o_clr[k]), 1);
        check_eq($sformatf("u%0d post-rst input_ready", k), 32'(o_ir[k]), 0);
        next_cycle();
    endtask

    // Feed words: W (if with_w) then x, with optional random gaps.
    task automatic load_words(input int k, input bit with_w, input bit from_idle,
                              input int stop_after, input bit gaps);
        int nw     = with_w ? rows_of(k) * cols_of(k) : 0;
        int total  = nw + cols_of(k);
        int i      = 0;
        int budget = 0;
        while (i < total && i < stop_after) begin
            logic v;
            v = gaps ? logic'($urandom_range(0, 2) != 0) : 1'b1;
            in_valid[k] = v;
            new_mat[k]  = (i == 0 && from_idle) ? logic'(with_w) : 1'($urandom_range(0, 1));
            out_ready[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq($sformatf("u%0d ld%0d input_ready", k, i), 32'(o_ir[k]), 1);
            check_eq($sformatf("u%0d ld%0d clear_acc", k, i), 32'(o_clr[k]), 0);
            check_eq($sformatf("u%0d ld%0d output_valid", k, i), 32'(o_ov[k]), 0);
            if (v && i < nw) begin
                check_eq($sformatf("u%0d ld%0d wr_en_w", k, i), 32'(o_wew[k]), 1);
                check_eq($sformatf("u%0d ld%0d wr_en_x", k, i), 32'(o_wex[k]), 0);
                check_eq($sformatf("u%0d ld%0d addr_w", k, i), 32'(o_addr_w[k]), i);
            end else if (v) begin
                check_eq($sformatf("u%0d ld%0d wr_en_x", k, i), 32'(o_wex[k]), 1);
                check_eq($sformatf("u%0d ld%0d wr_en_w", k, i), 32'(o_wew[k]), 0);
                check_eq($sformatf("u%0d ld%0d addr_x", k, i), 32'(o_addr_x[k]), i - nw);
            end else begin
                check_eq($sformatf("u%0d gap%0d wr_en_w", k, i), 32'(o_wew[k]), 0);
                check_eq($sformatf("u%0d gap%0d wr_en_x", k, i), 32'(o_wex[k]), 0);
            end
            if (v) i++;
            next_cycle();
            budget++;
            if (budget > 1000) begin
                check_eq($sformatf("u%0d load cycle budget", k), 32'(budget), 0);
                break;
            end
        end
        in_valid[k] = 1'b0;
    endtask

    // All rows of one vector; row hold_row sees hold_cycles of back-pressure.
    task automatic compute(input int k, input int hold_row, input int hold_cycles);
        int r_n = rows_of(k);
        int c_n = cols_of(k);
        int l_n = lat_of(k);
        for (int r = 0; r < r_n; r++) begin
            for (int t = 0; t < c_n + l_n; t++) begin
                in_valid[k]  = 1'($urandom_range(0, 1));
                new_mat[k]   = 1'($urandom_range(0, 1));
                out_ready[k] = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_eq($sformatf("u%0d r%0d t%0d addr_w", k, r, t), 32'(o_addr_w[k]),
                         (t < c_n) ? r * c_n + t : 0);
                check_eq($sformatf("u%0d r%0d t%0d addr_x", k, r, t), 32'(o_addr_x[k]),
                         (t < c_n) ? t : 0);
                check_eq($sformatf("u%0d r%0d t%0d en_acc", k, r, t), 32'(o_en[k]),
                         32'(t >= l_n));
                check_eq($sformatf("u%0d r%0d t%0d output_valid", k, r, t), 32'(o_ov[k]), 0);
                check_eq($sformatf("u%0d r%0d t%0d input_ready", k, r, t), 32'(o_ir[k]), 0);
                check_eq($sformatf("u%0d r%0d t%0d writes", k, r, t),
                         32'(o_wew[k] | o_wex[k]), 0);
                check_eq($sformatf("u%0d r%0d t%0d clear_acc", k, r, t), 32'(o_clr[k]), 0);
                next_cycle();
            end
            for (int j = 0; j <= ((r == hold_row) ? hold_cycles : 0); j++) begin
                bit hs = (j == ((r == hold_row) ? hold_cycles : 0));
                out_ready[k] = logic'(hs);
                in_valid[k]  = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_eq($sformatf("u%0d r%0d s%0d output_valid", k, r, j), 32'(o_ov[k]), 1);
                check_eq($sformatf("u%0d r%0d s%0d row_idx", k, r, j), 32'(o_row[k]), r);
                check_eq($sformatf("u%0d r%0d s%0d last_row", k, r, j), 32'(o_last[k]),
                         32'(r == r_n - 1));
                check_eq($sformatf("u%0d r%0d s%0d clear_acc", k, r, j), 32'(o_clr[k]),
                         32'(hs));
                check_eq($sformatf("u%0d r%0d s%0d input_ready", k, r, j), 32'(o_ir[k]), 0);
                check_eq($sformatf("u%0d r%0d s%0d writes", k, r, j),
                         32'(o_wew[k] | o_wex[k]), 0);
                check_eq($sformatf("u%0d r%0d s%0d en_acc", k, r, j), 32'(o_en[k]), 0);
                next_cycle();
            end
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        @(negedge clk);
        check_eq($sformatf("u%0d idle input_ready", k), 32'(o_ir[k]), 1);
        check_eq($sformatf("u%0d idle output_valid", k), 32'(o_ov[k]), 0);
        next_cycle();
    endtask

    task automatic run_unit(input int k);
        reset_dut(k);
        load_words(k, 1'b1, 1'b0, 1 << 30, 1'b0);
        compute(k, -1, 0);
        load_words(k, 1'b0, 1'b1, 1 << 30, 1'b1);
        compute(k, 1, 10);
        load_words(k, 1'b1, 1'b1, 1 << 30, 1'b1);
        compute(k, rows_of(k) - 1, int'($urandom_range(1, 5)));
        // abort in the middle of a W load, after word 4
        load_words(k, 1'b1, 1'b1, 5, 1'b1);
        reset_dut(k);
        load_words(k, 1'b1, 1'b0, 1 << 30, 1'b1);
        compute(k, -1, 0);
        // abort in the middle of MULT
        load_words(k, 1'b1, 1'b1, 1 << 30, 1'b0);
        next_cycle();
        next_cycle();
        reset_dut(k);
        load_words(k, 1'b1, 1'b0, 1 << 30, 1'b1);
        compute(k, int'($urandom_range(0, rows_of(k) - 1)), int'($urandom_range(0, 4)));
        for (int it = 0; it < 4; it++) begin
            load_words(k, 1'($urandom_range(0, 1)), 1'b1, 1 << 30, 1'b1);
            compute(k, int'($urandom_range(0, rows_of(k) - 1)), int'($urandom_range(0, 6)));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            new_mat[k]   = 1'b0;
            out_ready[k] = 1'b0;
        end
        #1;
        run_unit(0);
        run_unit(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
